// File: rtl/timer_pkg.sv
// Shared types and constants for the preset timer loader: FSM states, the BCD
// entry buffer layout and the keypad digit limits.
package timer_pkg;

  localparam int unsigned BCD_MAX      = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MAX_DIGITS   = 4;
  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned CNT_W        = 3;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Four-digit preset, most significant (tens of minutes) first
  typedef struct packed {
    logic [DIGIT_W-1:0] m10;
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] s10;
    logic [DIGIT_W-1:0] s1;
  } bcd_buf_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] code);
    return code <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/timer_preset_loader_tick_gen.sv
// Countdown tick divider: one-cycle tick every TICK_DIV enabled clocks,
// synchronous restart clears the count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic clrn,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == CW'(TICK_DIV - 1)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_preset_loader.sv
// Keypad preset entry and load/run sequencing for a BCD countdown chain.
// Optional build macro SEC_CLAMP_EN clamps seconds above 59 to 59 on load.
module timer_preset_loader
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_start,
  input  logic               key_clear,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] data_s1,
  output logic [DIGIT_W-1:0] data_s10,
  output logic [DIGIT_W-1:0] data_m1,
  output logic [DIGIT_W-1:0] data_m10,
  output logic               loadn,
  output logic               en,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               running,
  output logic               done
);

  state_t           state, state_nx;
  bcd_buf_t         bcd, bcd_nx, base_buf;
  logic [CNT_W-1:0] cnt_nx, base_cnt;
  logic             tick;

  // Next state, buffer and digit count
  always_comb begin
    state_nx = state;
    bcd_nx   = bcd;
    cnt_nx   = digit_cnt;
    base_buf = (state == DONE) ? '0 : bcd;
    base_cnt = (state == DONE) ? '0 : digit_cnt;
    if (key_clear) begin
      state_nx = IDLE;
      bcd_nx   = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE, ENTRY, DONE: begin
          if (key_valid) begin
            // A digit from DONE starts a fresh entry; start is dropped when a key arrives
            if (digit_ok(key_code) && (base_cnt < CNT_W'(MAX_DIGITS))) begin
              state_nx   = ENTRY;
              bcd_nx.m10 = base_buf.m1;
              bcd_nx.m1  = base_buf.s10;
              bcd_nx.s10 = base_buf.s1;
              bcd_nx.s1  = key_code;
              cnt_nx     = base_cnt + CNT_W'(1);
            end
          end else if (key_start && (state == ENTRY) && (digit_cnt != '0)) begin
            state_nx = LOAD;
`ifdef SEC_CLAMP_EN
            if (bcd.s10 > DIGIT_W'(SEC_TENS_MAX)) begin
              bcd_nx.s10 = DIGIT_W'(SEC_TENS_MAX);
              bcd_nx.s1  = DIGIT_W'(BCD_MAX);
            end
`endif
          end
        end
        LOAD:    state_nx = RUN;
        RUN:     if (timer_zero) state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      bcd       <= '0;
      digit_cnt <= '0;
      loadn     <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      bcd       <= bcd_nx;
      digit_cnt <= cnt_nx;
      loadn     <= (state_nx != LOAD);
      running   <= (state_nx == RUN);
      done      <= (state_nx == DONE);
    end
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .clrn    (clrn),
    .enable  (state == RUN),
    .restart (state != RUN),
    .tick    (tick)
  );

  assign data_m10 = bcd.m10;
  assign data_m1  = bcd.m1;
  assign data_s10 = bcd.s10;
  assign data_s1  = bcd.s1;

  // Gated by timer_zero so the chain never steps past zero on the final cycle
  assign en = (state == LOAD) | ((state == RUN) & tick & ~timer_zero);

endmodule

// File: tb/tb_timer_preset_loader.sv
// Directed bench for timer_preset_loader with TICK_DIV=4; honours SEC_CLAMP_EN.
module tb_timer_preset_loader;

  logic       clk = 1'b0;
  logic       clrn;
  logic       key_valid, key_start, key_clear, timer_zero;
  logic [3:0] key_code;
  logic [3:0] data_s1, data_s10, data_m1, data_m10;
  logic       loadn, en, running, done;
  logic [2:0] digit_cnt;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;

  timer_preset_loader #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_start  (key_start),
    .key_clear  (key_clear),
    .timer_zero (timer_zero),
    .data_s1    (data_s1),
    .data_s10   (data_s10),
    .data_m1    (data_m1),
    .data_m10   (data_m10),
    .loadn      (loadn),
    .en         (en),
    .digit_cnt  (digit_cnt),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign data = {data_m10, data_m1, data_s10, data_s1};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_code  = d;
    cyc();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic start();
    key_start = 1'b1;
    cyc();
    key_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, data, 16'h0000);
    chk({tag, "_cnt"}, 16'(digit_cnt), 16'd0);
    chk({tag, "_ctl"}, {12'd0, loadn, en, running, done}, 16'b1000);
  endtask

  initial begin
    clrn = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    key_start = 1'b0; key_clear = 1'b0; timer_zero = 1'b0;
    #2 clrn = 1'b0;
    #2 chk_reset_vals("reset");
    cyc(); cyc();
    clrn = 1'b1;
    cyc();

    // Enter 1,2,3,0 and start
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    chk("entry_data", data, 16'h1230);
    chk("entry_cnt", 16'(digit_cnt), 16'd4);
    start();
    chk("load_data", data, 16'h1230);
    chk("load_ctl", {14'd0, loadn, en}, 16'b01);
    cyc();
    chk("run_ctl", {13'd0, loadn, running, done}, 16'b110);
    for (int k = 0; k < 9; k++) begin
      chk("run_en", 16'(en), ((k == 4) || (k == 8)) ? 16'd1 : 16'd0);
      cyc();
    end
    cyc(); cyc(); cyc();
    chk("tick_k12", 16'(en), 16'd1);
    timer_zero = 1'b1;
    #1 chk("zero_gate_en", 16'(en), 16'd0);
    cyc();
    timer_zero = 1'b0;
    chk("done_ctl", {12'd0, loadn, en, running, done}, 16'b1001);
    for (int k = 0; k < 6; k++) begin
      chk("done_quiet", {14'd0, en, done}, 16'b01);
      cyc();
    end

    // Invalid code in DONE, then fresh entry with overflow digits
    key(4'd12);
    chk("done_ignore", {digit_cnt, done, data[11:0]}, {3'd4, 1'b1, 12'h230});
    key(4'd1); key(4'd2);
    chk("restart_entry", data, 16'h0012);
    key(4'd12);
    chk("code12_ignored", {digit_cnt, 1'b0, data[11:0]}, {3'd2, 1'b0, 12'h012});
    key(4'd3); key(4'd4); key(4'd5);
    chk("five_data", data, 16'h1234);
    chk("five_cnt", 16'(digit_cnt), 16'd4);

    // Clear wins over a simultaneous digit and start
    key_clear = 1'b1; key_start = 1'b1;
    key(4'd7);
    key_clear = 1'b0; key_start = 1'b0;
    chk_reset_vals("clear");
    start();
    chk("idle_start", 16'(loadn), 16'd1);

    // Digit wins over start in the same cycle
    key(4'd8);
    key_start = 1'b1;
    key(4'd9);
    key_start = 1'b0;
    chk("valid_over_start", {digit_cnt, loadn, data[11:0]}, {3'd2, 1'b1, 12'h089});
    cyc();
    chk("start_dropped", 16'(loadn), 16'd1);

    // Seconds 99
    key_clear = 1'b1; cyc(); key_clear = 1'b0;
    key(4'd9); key(4'd9);
    start();
`ifdef SEC_CLAMP_EN
    chk("load_99", data, 16'h0059);
`else
    chk("load_99", data, 16'h0099);
`endif
    chk("load_99_ctl", {14'd0, loadn, en}, 16'b01);

    // Reset in the middle of RUN
    cyc(); cyc(); cyc(); cyc();
    chk("pre_reset_run", 16'(running), 16'd1);
    clrn = 1'b0;
    #1 chk_reset_vals("mid_reset");
    cyc();
    clrn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("post_reset_quiet", {13'd0, loadn, en, running}, 16'b100);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_preset_loader.md
TIMER_PRESET_LOADER -- requirements
Module: timer_preset_loader

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clocks per countdown tick (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have port clrn, input, 1 bit, reset, asynchronous, active-low.
REQ-004 SHALL have port key_valid, input, 1 bit, one-cycle strobe, key_code valid.
REQ-005 SHALL have port key_code, input, 4 bits, keypad digit; values 10-15 ignored.
REQ-006 SHALL have port key_start, input, 1 bit, one-cycle start strobe.
REQ-007 SHALL have port key_clear, input, 1 bit, one-cycle clear strobe.
REQ-008 SHALL have port timer_zero, input, 1 bit, high when all downstream BCD digits read zero.
REQ-009 SHALL have ports data_s1, data_s10, data_m1, data_m10, output, 4 bits each, preset BCD digits to counter chain.
REQ-010 SHALL have port loadn, output, 1 bit, active-low synchronous load to counter chain.
REQ-011 SHALL have port en, output, 1 bit, count enable to counter chain.
REQ-012 SHALL have ports digit_cnt (output, 3 bits, digits entered 0-4), running (output, 1 bit), done (output, 1 bit).

Function
REQ-013 SHALL implement FSM states IDLE, ENTRY, LOAD, RUN, DONE.
REQ-014 SHALL, on accepted digit, shift buffer left: m10<=m1, m1<=s10, s10<=s1, s1<=key_code; digit_cnt+1.
REQ-015 SHALL accept digits only in IDLE, ENTRY, DONE; first digit moves IDLE/DONE to ENTRY, restarting from zeroed buffer if from DONE.
REQ-016 SHALL ignore digits when digit_cnt=4 or key_code>9; buffer and digit_cnt unchanged.
REQ-017 SHALL move ENTRY->LOAD on key_start when digit_cnt>0; key_start ignored in all other states.
REQ-018 SHALL hold loadn=0 and en=1 for exactly the single LOAD cycle, data_* stable; loadn=1 otherwise.
REQ-019 SHALL move LOAD->RUN unconditionally after one cycle; running=1 only in RUN.
REQ-020 SHALL, in RUN, pulse en high one cycle every TICK_DIV clocks; first pulse TICK_DIV clocks after RUN entry.
REQ-021 SHALL, in RUN, go to DONE on the cycle timer_zero=1 is sampled; that cycle en=0 and no further pulses.
REQ-022 SHALL hold done=1 only in DONE, en=0, loadn=1.
REQ-023 SHALL, on key_clear in any state, go to IDLE next cycle, zero buffer and digit_cnt, en=0.
REQ-024 SHALL prioritise key_clear over key_valid and key_start; key_valid over key_start in the same cycle (start dropped).

Reset
REQ-025 SHALL, on clrn=0, immediately force state IDLE, data_*=0, digit_cnt=0, loadn=1, en=0, running=0, done=0, divider=0.
REQ-026 SHALL abort RUN/LOAD on mid-operation reset with no residual en or loadn pulse after release.

Configuration
REQ-027 SHALL, with SEC_CLAMP_EN defined, clamp seconds on LOAD entry: if {s10,s1}>59 then s10=5, s1=9 (data_* updated before the LOAD cycle).
REQ-028 SHALL, without SEC_CLAMP_EN, pass entered digits unmodified (e.g. 0:75 loads as 0,0,7,5).

Structure
REQ-029 SHALL place FSM state enum, BCD_MAX=9, SEC_TENS_MAX=5, MAX_DIGITS=4 in shared package timer_pkg.
REQ-030 SHALL implement tick divider as sub-module tick_gen (enable, sync restart, one-cycle tick output).

Verification (TICK_DIV=4)
REQ-031 SHALL verify keys 1,2,3,0 then start -> data m10..s1=1,2,3,0, loadn=0 one cycle, then en every 4 clocks.
REQ-032 SHALL verify five digits 1-5 -> buffer 1,2,3,4, digit_cnt=4, fifth ignored; key_code=12 ignored.
REQ-033 SHALL verify RUN with timer_zero=1 asserted -> DONE next cycle, done=1, no en pulse.
REQ-034 SHALL verify key_clear with key_valid same cycle in ENTRY -> IDLE, buffer 0, digit_cnt=0.
REQ-035 SHALL verify keys 9,9 start -> with SEC_CLAMP_EN loads 0,0,5,9; without loads 0,0,9,9.
REQ-036 SHALL verify clrn pulse mid-RUN -> all outputs at reset values, no en after release until new LOAD.
